// File: rtl/div_pkg.sv
// Shared definitions for the divider issue wrapper: FSM encoding, default
// sizing and the counter width helper.
package div_pkg;

  localparam int unsigned DIV_NUM_BITS = 24;
  localparam int unsigned DIV_LATENCY  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } div_state_e;

  // A latency of 1 still needs a one-bit register to hold the count.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/div_cycle_cnt.sv
// Free-running cycle counter for the RUN phase: counts 0..C_LATENCY-1 while
// enabled, wraps at terminal count, and can be cleared synchronously.
module div_cycle_cnt
  import div_pkg::*;
#(
  parameter int unsigned C_LATENCY = DIV_LATENCY
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = cnt_width(C_LATENCY);
  localparam logic [W-1:0] LAST = W'(C_LATENCY - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/div_issue.sv
// Request/response wrapper around an external fixed-latency divider: latches
// the operands, resets and clocks the divider, and captures its quotient.
module div_issue
  import div_pkg::*;
#(
  parameter int unsigned C_NUM_BITS = DIV_NUM_BITS,
  parameter int unsigned C_LATENCY  = DIV_LATENCY
) (
  input  logic                  CK,
  input  logic                  RN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [C_NUM_BITS-1:0] IN_A,
  input  logic [C_NUM_BITS-1:0] IN_B,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [C_NUM_BITS-1:0] OUT_Q,
  output logic                  OUT_ERR,
  output logic                  DIV_RN,
  output logic                  DIV_E,
  output logic [C_NUM_BITS-1:0] DIV_A,
  output logic [C_NUM_BITS-1:0] DIV_B,
  input  logic [C_NUM_BITS-1:0] DIV_Q
);

  div_state_e            state_q;
  logic [C_NUM_BITS-1:0] a_q;
  logic [C_NUM_BITS-1:0] b_q;
  logic [C_NUM_BITS-1:0] res_q;
  logic                  err_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  div_e_q;
  logic                  cnt_tc;

  div_cycle_cnt #(
    .C_LATENCY(C_LATENCY)
  ) u_cnt (
    .clk_i (CK),
    .rst_ni(RN),
    .clr_i (state_q != ST_RUN),
    .en_i  (state_q == ST_RUN),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      div_e_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (IN_VALID) begin
            a_q        <= IN_A;
            b_q        <= IN_B;
            in_ready_q <= 1'b0;
            // A zero divisor never touches the divider; answer immediately.
            if (IN_B == '0) begin
              state_q     <= ST_DONE;
              res_q       <= '1;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ST_CLEAR;
              err_q   <= 1'b0;
              div_e_q <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (cnt_tc) begin
            state_q     <= ST_DONE;
            res_q       <= DIV_Q;
            div_e_q     <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Divider reset follows RN immediately so it is held in reset alongside us.
  assign DIV_RN    = RN & (state_q != ST_CLEAR);
  assign DIV_E     = div_e_q;
  assign DIV_A     = a_q;
  assign DIV_B     = b_q;
  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_Q     = res_q;
  assign OUT_ERR   = err_q;

endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue with a behavioural fixed-latency divider.
module tb_div_issue;

  localparam int NB  = 24;
  localparam int LAT = 32;

  logic          CK = 1'b0;
  logic          RN = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [NB-1:0] IN_A = '0;
  logic [NB-1:0] IN_B = '0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [NB-1:0] OUT_Q;
  logic          OUT_ERR;
  logic          DIV_RN;
  logic          DIV_E;
  logic [NB-1:0] DIV_A;
  logic [NB-1:0] DIV_B;
  logic [NB-1:0] DIV_Q;

  int errors = 0;
  int checks = 0;

  always #5 CK = ~CK;

  div_issue #(
    .C_NUM_BITS(NB),
    .C_LATENCY (LAT)
  ) dut (
    .CK       (CK),
    .RN       (RN),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_A     (IN_A),
    .IN_B     (IN_B),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_Q    (OUT_Q),
    .OUT_ERR  (OUT_ERR),
    .DIV_RN   (DIV_RN),
    .DIV_E    (DIV_E),
    .DIV_A    (DIV_A),
    .DIV_B    (DIV_B),
    .DIV_Q    (DIV_Q)
  );

  // Divider model: quotient is valid only once enough enabled cycles have
  // elapsed since its reset; before that it shows a poison value.
  int en_cnt = 0;
  always @(posedge CK) begin
    if (!DIV_RN) en_cnt <= 0;
    else if (DIV_E && en_cnt < 1000) en_cnt <= en_cnt + 1;
  end
  assign DIV_Q = (en_cnt >= LAT - 1 && DIV_B != 0) ? DIV_A / DIV_B : 24'hBADBAD;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [NB-1:0] q;
    logic          err;
    int            lat;
    int            hold;
  } vec_t;

  vec_t vecs[7];

  task automatic run_txn(input logic [NB-1:0] a, input logic [NB-1:0] b,
                         input logic [NB-1:0] q_exp, input logic err_exp,
                         input int lat_exp, input int hold);
    int   lat, clr_n, run_n;
    logic rdy_seen;
    logic [NB-1:0] q_seen;
    logic nz;
    nz = (b != 0);
    @(negedge CK);
    chk("in_ready_idle", IN_READY, 1);
    IN_VALID = 1'b1; IN_A = a; IN_B = b; OUT_READY = 1'b0;
    @(posedge CK); #1;
    IN_VALID = 1'b0; IN_A = ~a; IN_B = b + 3;
    lat = 0; clr_n = 0; run_n = 0; rdy_seen = 1'b0;
    while (lat < 200) begin
      @(negedge CK);
      lat++;
      if (OUT_VALID) break;
      if (IN_READY) rdy_seen = 1'b1;
      if (!DIV_RN) clr_n++;
      else if (DIV_E) run_n++;
    end
    $display("txn a=%0h b=%0h -> q=%0h err=%0b lat=%0d", a, b, OUT_Q, OUT_ERR, lat);
    chk("latency", lat, lat_exp);
    chk("out_q", OUT_Q, q_exp);
    chk("out_err", OUT_ERR, err_exp);
    chk("clear_cycles", clr_n, nz ? 1 : 0);
    chk("run_cycles", run_n, nz ? LAT : 0);
    chk("in_ready_busy", rdy_seen, 0);
    chk("div_e_done", DIV_E, 0);
    chk("div_a_held", DIV_A, a);
    chk("div_b_held", DIV_B, b);
    q_seen = OUT_Q;
    for (int i = 0; i < hold; i++) begin
      @(negedge CK);
      chk("hold_valid", OUT_VALID, 1);
      chk("hold_q", OUT_Q, q_seen);
      chk("hold_in_ready", IN_READY, 0);
    end
    OUT_READY = 1'b1;
    @(negedge CK);
    chk("post_hs_valid", OUT_VALID, 0);
    chk("post_hs_ready", IN_READY, 1);
    OUT_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{a: 24'd100,     b: 24'd7,       q: 24'd14,     err: 1'b0, lat: 34, hold: 0};
    vecs[1] = '{a: 24'd5,       b: 24'd0,       q: 24'hFFFFFF, err: 1'b1, lat: 1,  hold: 0};
    vecs[2] = '{a: 24'hFFFFFF,  b: 24'd1,       q: 24'hFFFFFF, err: 1'b0, lat: 34, hold: 10};
    vecs[3] = '{a: 24'd0,       b: 24'd9,       q: 24'd0,      err: 1'b0, lat: 34, hold: 0};
    vecs[4] = '{a: 24'd1000,    b: 24'd1001,    q: 24'd0,      err: 1'b0, lat: 34, hold: 2};
    vecs[5] = '{a: 24'hFFFFFF,  b: 24'hFFFFFF,  q: 24'd1,      err: 1'b0, lat: 34, hold: 0};
    vecs[6] = '{a: 24'h123456,  b: 24'd100,     q: 24'd11930,  err: 1'b0, lat: 34, hold: 0};

    // Reset state
    repeat (2) @(negedge CK);
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_q", OUT_Q, 0);
    chk("rst_out_err", OUT_ERR, 0);
    chk("rst_div_e", DIV_E, 0);
    chk("rst_div_a", DIV_A, 0);
    chk("rst_div_b", DIV_B, 0);
    chk("rst_div_rn", DIV_RN, 0);
    RN = 1'b1;
    @(negedge CK);
    chk("div_rn_released", DIV_RN, 1);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].err, vecs[i].lat, vecs[i].hold);
    end

    // Reset in the middle of RUN, then a fresh request
    @(negedge CK);
    IN_VALID = 1'b1; IN_A = 24'd100; IN_B = 24'd7;
    @(posedge CK); #1;
    IN_VALID = 1'b0;
    repeat (12) @(negedge CK);
    RN = 1'b0;
    @(negedge CK);
    $display("mid-run reset: valid=%0b div_e=%0b div_rn=%0b ready=%0b", OUT_VALID, DIV_E, DIV_RN, IN_READY);
    chk("mrst_out_valid", OUT_VALID, 0);
    chk("mrst_div_e", DIV_E, 0);
    chk("mrst_div_rn", DIV_RN, 0);
    chk("mrst_in_ready", IN_READY, 1);
    chk("mrst_out_q", OUT_Q, 0);
    RN = 1'b1;
    run_txn(24'd9, 24'd3, 24'd3, 1'b0, 34, 0);

    // Back-to-back with IN_VALID held high
    @(negedge CK);
    chk("b2b_ready", IN_READY, 1);
    IN_VALID = 1'b1; IN_A = 24'd50; IN_B = 24'd5; OUT_READY = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge CK);
      n++;
      if (OUT_VALID) break;
    end
    $display("b2b first: q=%0h err=%0b lat=%0d", OUT_Q, OUT_ERR, n);
    chk("b2b1_lat", n, 34);
    chk("b2b1_q", OUT_Q, 24'd10);
    chk("b2b1_err", OUT_ERR, 0);
    IN_B = 24'd0;
    @(negedge CK);
    chk("b2b_gap_valid", OUT_VALID, 0);
    chk("b2b_gap_ready", IN_READY, 1);
    @(negedge CK);
    $display("b2b second: q=%0h err=%0b valid=%0b", OUT_Q, OUT_ERR, OUT_VALID);
    chk("b2b2_valid", OUT_VALID, 1);
    chk("b2b2_q", OUT_Q, 24'hFFFFFF);
    chk("b2b2_err", OUT_ERR, 1);
    chk("b2b2_div_e", DIV_E, 0);
    IN_VALID = 1'b0;
    @(negedge CK);
    chk("b2b_end_ready", IN_READY, 1);
    chk("b2b_end_valid", OUT_VALID, 0);
    OUT_READY = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
